speed_tick_gen: RTL and testbench

- Parametrised successor to the fixed half/quarter/eighth-second enable generators.
- A single shared counter produces a one-cycle Tick at one of NUM_LEVELS speeds, with period BASE_DIV >> Level.
- Level is changed by Faster/Slower pulses, or automatically after a set number of ticks.
- Drives the car-game movement/scroll logic and replaces per-speed counter instances.

---
 rtl/speed_tick_gen.sv | 135 +++++++++++++
 tb/tb_speed_tick_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/speed_tick_gen.sv
// Purpose : shared-counter tick generator, period BASE_DIV >> Level,
//           with manual (Faster/Slower) and automatic speed stepping.
// Latency : Tick is registered; it rises the cycle after the P-th enabled edge.
// Backpressure: none; Enable=0 freezes the period and tick-count state,
//           while Faster/Slower requests are still honoured.
//
// Ports:
//   Clock     rising-edge system clock
//   Reset     asynchronous, active-high reset
//   Enable    1 = count, 0 = pause (count and level tick counter hold)
//   Faster    single-cycle request for Level+1
//   Slower    single-cycle request for Level-1
//   AutoAccel 1 = step Level up after AUTO_ACCEL_TICKS ticks at one level
//   Tick      one-cycle pulse, once per period
//   Level     current speed level, 0..NUM_LEVELS-1
//   AtMax     combinational, Level == NUM_LEVELS-1
module speed_tick_gen #(
  parameter int BASE_DIV         = 25000000,
  parameter int NUM_LEVELS       = 4,
  parameter int CNT_W            = 26,
  parameter int LVL_W            = 2,
  parameter int AUTO_ACCEL_TICKS = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Faster,
  input  logic             Slower,
  input  logic             AutoAccel,
  output logic             Tick,
  output logic [LVL_W-1:0] Level,
  output logic             AtMax
);

  // The level tick counter must be able to hold AUTO_ACCEL_TICKS itself,
  // because it saturates there rather than wrapping.
  localparam int ACC_W = $clog2(AUTO_ACCEL_TICKS + 1);

  localparam logic [LVL_W-1:0] MAX_LVL    = LVL_W'(NUM_LEVELS - 1);
  localparam logic [ACC_W-1:0] ACC_SAT    = ACC_W'(AUTO_ACCEL_TICKS);
  localparam logic [31:0]      BASE_DIV_U = 32'(BASE_DIV);

  // State registers
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;

  // Next-state values
  logic [CNT_W-1:0] count_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             tick_nxt;

  // Decoded conditions
  logic [31:0]      period_full;
  logic [CNT_W-1:0] period_last;
  logic             at_max;
  logic             at_min;
  logic             req_up;
  logic             req_dn;
  logic             man_chg;
  logic             period_done;
  logic [ACC_W-1:0] acc_inc;
  logic             auto_up;

  // Period is a pure shift of the base divider; the legal parameter range
  // keeps it at least 2, so period_last never underflows.
  assign period_full = BASE_DIV_U >> Level;
  assign period_last = CNT_W'(period_full - 32'd1);

  assign at_max = (Level == MAX_LVL);
  assign at_min = (Level == '0);

  // Simultaneous Faster+Slower, or a request against a limit, is a no-op:
  // it must not clear the count or the tick counter either.
  assign req_up  = Faster & ~Slower & ~at_max;
  assign req_dn  = Slower & ~Faster & ~at_min;
  assign man_chg = req_up | req_dn;

  // A real level change suppresses the tick even if count was at P-1,
  // so a count built up at a slow level never overshoots a faster period.
  assign period_done = Enable & ~man_chg & (count == period_last);

  // Saturating increment of the level tick counter.
  assign acc_inc = (acc == ACC_SAT) ? acc : acc + ACC_W'(1);

  // Using the saturated value means a counter that filled up while
  // AutoAccel was low triggers the level-up on the very next tick once
  // AutoAccel is raised.
  assign auto_up = period_done & AutoAccel & ~at_max & (acc_inc == ACC_SAT);

  always_comb begin
    count_nxt = count;
    acc_nxt   = acc;
    level_nxt = Level;
    tick_nxt  = 1'b0;

    if (man_chg) begin
      // Manual change wins over any auto step in the same edge.
      count_nxt = '0;
      acc_nxt   = '0;
      level_nxt = req_up ? Level + LVL_W'(1) : Level - LVL_W'(1);
    end else if (Enable) begin
      if (period_done) begin
        count_nxt = '0;
        tick_nxt  = 1'b1;
        if (auto_up) begin
          // Tick still fires; count already restarts from 0 at new period.
          level_nxt = Level + LVL_W'(1);
          acc_nxt   = '0;
        end else begin
          acc_nxt = acc_inc;
        end
      end else begin
        count_nxt = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      acc   <= '0;
      Level <= '0;
      Tick  <= 1'b0;
    end else begin
      count <= count_nxt;
      acc   <= acc_nxt;
      Level <= level_nxt;
      Tick  <= tick_nxt;
    end
  end

  assign AtMax = at_max;

endmodule

// File: tb/tb_speed_tick_gen.sv
module tb_speed_tick_gen;

  localparam int BASE_DIV   = 16;
  localparam int NUM_LEVELS = 4;
  localparam int LVL_W      = 2;
  localparam int AUTO       = 3;
  localparam int CNT_W      = 5;

  logic             Clock     = 1'b0;
  logic             Reset     = 1'b1;
  logic             Enable    = 1'b0;
  logic             Faster    = 1'b0;
  logic             Slower    = 1'b0;
  logic             AutoAccel = 1'b0;
  logic             Tick;
  logic [LVL_W-1:0] Level;
  logic             AtMax;

  speed_tick_gen #(
    .BASE_DIV        (BASE_DIV),
    .NUM_LEVELS      (NUM_LEVELS),
    .CNT_W           (CNT_W),
    .LVL_W           (LVL_W),
    .AUTO_ACCEL_TICKS(AUTO)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable   (Enable),
    .Faster   (Faster),
    .Slower   (Slower),
    .AutoAccel(AutoAccel),
    .Tick     (Tick),
    .Level    (Level),
    .AtMax    (AtMax)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int tick;
    int level;
    int atmax;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: level, number of enabled edges into the current
  // period (1..P), and ticks seen at the current level.
  int m_level;
  int m_phase;
  int m_ticks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_phase = 0;
    m_ticks = 0;
  endtask

  // Apply inputs for the coming rising edge and queue what the outputs
  // must look like after that edge.
  task automatic drive(input bit en, input bit f, input bit s, input bit aa);
    int   period;
    bit   up;
    bit   dn;
    exp_t e;
    Enable    = en;
    Faster    = f;
    Slower    = s;
    AutoAccel = aa;
    period = BASE_DIV / (2 ** m_level);
    up = f && !s && (m_level < NUM_LEVELS - 1);
    dn = s && !f && (m_level > 0);
    e.tick = 0;
    if (up || dn) begin
      m_level = up ? m_level + 1 : m_level - 1;
      m_phase = 0;
      m_ticks = 0;
    end else if (en) begin
      m_phase++;
      if (m_phase == period) begin
        m_phase = 0;
        e.tick  = 1;
        m_ticks = (m_ticks + 1 > AUTO) ? AUTO : m_ticks + 1;
        if (aa && m_ticks >= AUTO && m_level < NUM_LEVELS - 1) begin
          m_level++;
          m_ticks = 0;
        end
      end
    end
    e.level = m_level;
    e.atmax = (m_level == NUM_LEVELS - 1) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit en, input bit f, input bit s, input bit aa);
    @(negedge Clock);
    drive(en, f, s, aa);
  endtask

  task automatic idle(input int n, input bit en, input bit aa);
    for (int i = 0; i < n; i++) cyc(en, 1'b0, 1'b0, aa);
  endtask

  // Assert Reset between edges and check the outputs clear with no edge.
  task automatic do_reset();
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    check("async_rst_tick", 32'(Tick), 0);
    check("async_rst_level", 32'(Level), 0);
    check("async_rst_atmax", 32'(AtMax), 0);
    Enable = 1'b1;
    Faster = 1'b1;
    repeat (2) @(negedge Clock);
    check("held_rst_tick", 32'(Tick), 0);
    check("held_rst_level", 32'(Level), 0);
    sb.delete();
  endtask

  task automatic release_rst(input bit aa);
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, aa);
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tick", 32'(Tick), 32'(e.tick));
        check("level", 32'(Level), 32'(e.level));
        check("atmax", 32'(AtMax), 32'(e.atmax));
      end
    end
  end

  initial begin
    bit aa;
    model_reset();

    // Power-on reset state
    repeat (3) @(negedge Clock);
    check("por_tick", 32'(Tick), 0);
    check("por_level", 32'(Level), 0);
    check("por_atmax", 32'(AtMax), 0);

    // 1: free-running at level 0
    @(negedge Clock);
    Reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(50, 1'b1, 1'b0);

    // 2: five Faster pulses, saturating at level 3
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b1, 1'b0);
    end
    idle(10, 1'b1, 1'b0);

    // 3: Faster exactly on the count==P-1 edge, then Faster+Slower together
    do_reset();
    release_rst(1'b0);
    idle(14, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);

    // 4: auto acceleration through all levels
    do_reset();
    release_rst(1'b1);
    idle(16 * 3 + 8 * 3 + 4 * 3 + 20, 1'b1, 1'b1);

    // 5: pause at count 10 with an ignored Slower at level 0
    do_reset();
    release_rst(1'b0);
    idle(9, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, (i == 5), 1'b0);
    idle(20, 1'b1, 1'b0);

    // 6: async reset at level 2, count 3
    do_reset();
    release_rst(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0);
    do_reset();
    release_rst(1'b0);
    idle(40, 1'b1, 1'b0);

    // Randomised traffic, including occasional AutoAccel toggles and resets
    aa = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) aa = ~aa;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        release_rst(aa);
      end else begin
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0, aa);
      end
    end

    @(posedge Clock);
    #2;
    check("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
